// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter with write FIFO and internal baud divider
// A write queue feeds a start/data/parity/stop framer; frames run back-to-back while the queue has words.

module uart_tx_fifo_q #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [WIDTH-1:0]             m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Readiness uses the pre-edge count, so a same-cycle pop never frees a slot for this write.
  assign s_tready = (count != CNT_W'(DEPTH));
  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge sysclk) begin
    if (push) begin
      mem[wr_ptr] <= s_tdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      overrun <= s_tvalid && !s_tready;
    end
  end

endmodule

module uart_tx_fifo #(
  parameter int CLK_DIV    = 10417,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 sysclk,
  input  logic                                 reset,
  input  logic [DATA_BITS-1:0]                 TX_DATA,
  input  logic                                 TX_EN,
  output logic                                 UART_TX,
  output logic                                 TX_STATUS,
  output logic                                 TX_FULL,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      TX_COUNT,
  output logic                                 TX_OVERRUN
);

  localparam int   BAUD_W      = $clog2(CLK_DIV);
  localparam int   IDX_W       = $clog2(DATA_BITS);
  localparam int   FCNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic PAR_EN      = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD     = (PARITY == 1);
  localparam logic TWO_STOP    = (STOP_BITS == 2);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state_q;
  state_t               state_d;
  logic [BAUD_W-1:0]    baud_q;
  logic [BAUD_W-1:0]    baud_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 par_d;
  logic                 line_q;
  logic                 line_d;
  logic                 status_q;
  logic                 status_d;
  logic                 start_frame;
  logic                 pop;
  logic                 bit_end;
  logic                 wr_ok;
  logic                 fifo_ready;
  logic                 fifo_valid;
  logic [DATA_BITS-1:0] fifo_data;

  uart_tx_fifo_q #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_queue (
    .sysclk   (sysclk),
    .reset    (reset),
    .s_tdata  (TX_DATA),
    .s_tvalid (TX_EN),
    .s_tready (fifo_ready),
    .m_tdata  (fifo_data),
    .m_tvalid (fifo_valid),
    .m_tready (pop),
    .count    (TX_COUNT),
    .overrun  (TX_OVERRUN)
  );

  assign TX_FULL   = (TX_COUNT == FCNT_W'(FIFO_DEPTH));
  assign UART_TX   = line_q;
  assign TX_STATUS = status_q;
  assign bit_end   = (baud_q == '0);
  assign wr_ok     = TX_EN && fifo_ready;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    line_d      = line_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    if (state_q != IDLE) begin
      baud_d = bit_end ? BAUD_RELOAD : baud_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (fifo_valid) begin
          start_frame = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          line_d  = shift_q[0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            if (PAR_EN) begin
              state_d = PAR;
              line_d  = par_q;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
              idx_d   = '0;
            end
          end else begin
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          line_d  = 1'b1;
          idx_d   = '0;
        end
      end
      STOP: begin
        // idx_q counts completed stop bits when two are configured.
        if (bit_end) begin
          if (TWO_STOP && idx_q == '0) begin
            idx_d = IDX_W'(1);
          end else if (fifo_valid) begin
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
            line_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase

    if (start_frame) begin
      pop     = 1'b1;
      state_d = START;
      line_d  = 1'b0;
      shift_d = fifo_data;
      par_d   = (^fifo_data) ^ PAR_ODD;
      baud_d  = BAUD_RELOAD;
    end

    // Idle after this edge: framer heading to IDLE and the queue left empty.
    status_d = (state_d == IDLE) &&
               ((TX_COUNT == '0 && !wr_ok) ||
                (TX_COUNT == FCNT_W'(1) && pop && !wr_ok));
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      line_q   <= 1'b1;
      status_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      line_q   <= line_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a frame-level model
// Three configurations run side by side; each model predicts the line from frame start times and bit arithmetic.

module tb_uart_tx_fifo;

  localparam int NCFG = 3;

  logic                      sysclk = 1'b0;
  logic                      reset;
  logic [NCFG-1:0]           tx_en;
  logic [NCFG-1:0][8:0]      tx_data;
  logic [NCFG-1:0]           tx_line;
  logic [NCFG-1:0]           status;
  logic [NCFG-1:0]           full;
  logic [NCFG-1:0]           ovr;
  logic [NCFG-1:0][3:0]      cnt_w;

  int errors = 0;
  int checks = 0;
  int trk    = 0;
  int peak   = 0;
  int pulses = 0;

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int CD   = 4;
    localparam int DB   = (g == 0) ? 8 : (g == 1) ? 7 : 9;
    localparam int PM   = (g == 0) ? 0 : (g == 1) ? 2 : 1;
    localparam int SB   = (g == 2) ? 2 : 1;
    localparam int DP   = (g == 2) ? 8 : 4;
    localparam int CW   = $clog2(DP + 1);
    localparam int PE   = (PM == 1 || PM == 2) ? 1 : 0;
    localparam int FLEN = CD * (1 + DB + PE + SB);

    logic [CW-1:0] count;
    int q[$];
    int n        = 0;
    int fr_start = 0;
    int fr_end   = 0;
    int cur      = 0;
    int pre      = 0;
    int e_line   = 1;
    int e_ovr    = 0;
    int e_busy   = 0;
    bit acc;

    assign cnt_w[g] = 4'(count);

    uart_tx_fifo #(
      .CLK_DIV    (CD),
      .DATA_BITS  (DB),
      .PARITY     (PM),
      .STOP_BITS  (SB),
      .FIFO_DEPTH (DP)
    ) dut (
      .sysclk     (sysclk),
      .reset      (reset),
      .TX_DATA    (tx_data[g][DB-1:0]),
      .TX_EN      (tx_en[g]),
      .UART_TX    (tx_line[g]),
      .TX_STATUS  (status[g]),
      .TX_FULL    (full[g]),
      .TX_COUNT   (count),
      .TX_OVERRUN (ovr[g])
    );

    // Bit k of a frame: 0 = start, 1..DB = data LSB first, then parity, then stop ones.
    function automatic int fbit(input int w, input int k);
      int wm;
      wm = w & ((1 << DB) - 1);
      if (k == 0) return 0;
      if (k <= DB) return (wm >> (k - 1)) & 1;
      if (PE == 1 && k == DB + 1) return ($countones(wm) % 2) ^ ((PM == 1) ? 1 : 0);
      return 1;
    endfunction

    always @(posedge sysclk) begin
      if (!reset) begin
        q.delete();
        n        = 0;
        fr_start = 0;
        fr_end   = 0;
        e_ovr    = 0;
        e_line   = 1;
        e_busy   = 0;
      end else begin
        pre = q.size();
        acc = tx_en[g] && (pre < DP);
        if (pre > 0 && n >= fr_end) begin
          cur      = q.pop_front();
          fr_start = n;
          fr_end   = n + FLEN;
        end
        if (acc) q.push_back(int'(tx_data[g]) & ((1 << DB) - 1));
        e_ovr  = (tx_en[g] && !acc) ? 1 : 0;
        e_busy = (n < fr_end) ? 1 : 0;
        e_line = (e_busy != 0) ? fbit(cur, (n - fr_start) / CD) : 1;
        n++;
      end
      #1;
      check($sformatf("c%0d.line", g),    int'(tx_line[g]), e_line);
      check($sformatf("c%0d.status", g),  int'(status[g]), (e_busy == 0 && q.size() == 0) ? 1 : 0);
      check($sformatf("c%0d.count", g),   int'(count), q.size());
      check($sformatf("c%0d.full", g),    int'(full[g]), (q.size() == DP) ? 1 : 0);
      check($sformatf("c%0d.overrun", g), int'(ovr[g]), e_ovr);
    end
  end

  task automatic tick();
    @(negedge sysclk);
    if (int'(cnt_w[trk]) > peak) peak = int'(cnt_w[trk]);
    pulses += int'(ovr[trk]);
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (t < limit && status != '1) begin
      tick();
      t++;
    end
    if (status != '1) check("idle_timeout", int'(status), (1 << NCFG) - 1);
  endtask

  task automatic track(input int g);
    trk    = g;
    peak   = 0;
    pulses = 0;
  endtask

  initial begin
    logic [9:0] seq;
    int wc [NCFG];
    int lows;
    int t;

    reset   = 1'b0;
    tx_en   = '0;
    tx_data = '0;
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);

    // Single frame: 0xA5 on 8N1, 0x07 on 7E1 and 9O2.
    tx_data[0] = 9'h0A5;
    tx_data[1] = 9'h007;
    tx_data[2] = 9'h007;
    tx_en      = '1;
    @(negedge sysclk);
    tx_en = '0;
    check("busy_after_write", int'(status[0]), 0);
    repeat (2) @(negedge sysclk);
    for (int k = 0; k < 10; k++) begin
      seq[k] = tx_line[0];
      if (k == 8) check("parity_even", int'(tx_line[1]), 1);
      if (k < 9) repeat (4) @(negedge sysclk);
    end
    check("a5_sequence", int'(seq), int'(10'b1101001010));
    repeat (2) @(negedge sysclk);
    check("status_before_end", int'(status[0]), 0);
    @(negedge sysclk);
    check("status_at_end", int'(status[0]), 1);
    @(negedge sysclk);
    check("parity_odd", int'(tx_line[2]), 0);
    wait_idle(200);

    // Back-to-back frames.
    track(2);
    for (int i = 0; i < 3; i++) begin
      tx_en = '1;
      for (int g = 0; g < NCFG; g++) tx_data[g] = 9'(8'h11 * (i + 1));
      tick();
    end
    tx_en = '0;
    wait_idle(400);
    check("b2b_peak_count", peak, 2);

    // Overflow: six writes into a four-deep queue.
    track(0);
    for (int i = 0; i < 6; i++) begin
      tx_en = '1;
      for (int g = 0; g < NCFG; g++) tx_data[g] = 9'(i);
      tick();
    end
    tx_en = '0;
    wait_idle(600);
    check("overrun_pulses", pulses, 1);
    check("overflow_peak", peak, 4);

    // Wrap-around: bursts of 4 and 6 paced by TX_FULL.
    track(1);
    foreach (wc[g]) wc[g] = 0;
    for (int b = 0; b < 2; b++) begin
      t = 0;
      while (t < 1000 && (wc[0] < 4 + 6 * b || wc[1] < 4 + 6 * b || wc[2] < 4 + 6 * b)) begin
        for (int g = 0; g < NCFG; g++) begin
          if (wc[g] < 4 + 6 * b && !full[g]) begin
            tx_en[g]   = 1'b1;
            tx_data[g] = 9'(9'h040 + wc[g]);
            wc[g]++;
          end else begin
            tx_en[g] = 1'b0;
          end
        end
        tick();
        t++;
      end
      tx_en = '0;
      wait_idle(800);
    end
    check("wrap_words", wc[1], 10);
    check("wrap_overrun", pulses, 0);

    // Randomized traffic with frequent overflows.
    for (int c = 0; c < 1500; c++) begin
      for (int g = 0; g < NCFG; g++) begin
        tx_en[g]   = ($urandom_range(0, 9) < 3);
        tx_data[g] = 9'($urandom);
      end
      @(negedge sysclk);
    end
    tx_en = '0;
    wait_idle(1000);

    // Reset in the middle of a data bit.
    tx_data = '0;
    tx_en   = '1;
    @(negedge sysclk);
    tx_en = '0;
    repeat (9) @(negedge sysclk);
    check("pre_reset_low", int'(tx_line[0]), 0);
    #2 reset = 1'b0;
    #1 check("reset_line_high", int'(tx_line), (1 << NCFG) - 1);
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    check("post_reset_status", int'(status), (1 << NCFG) - 1);
    check("post_reset_count", int'(cnt_w[0]), 0);
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge sysclk);
      if (tx_line != '1) lows++;
    end
    check("line_quiet_after_reset", lows, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised single-clock UART transmitter. Generalises the fixed 8N1 sender.
- Adds an internal baud divider, so no separate baud clock is needed.
- Data width, parity and stop-bit count are configurable, and a write FIFO allows back-to-back frames.
- Sits between the CPU peripheral bus (UART TX register write) and the board TX pin.

Parameters:
CLK_DIV, 10417, sysclk cycles per UART bit (>=2); 100 MHz / 9600 baud
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, entries in the TX FIFO, power of 2, >=2

Ports:
sysclk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
TX_DATA  input  DATA_BITS  data word to send
TX_EN  input  1  write strobe, one word per cycle high
UART_TX  output  1  serial line, idle high
TX_STATUS  output  1  1 = idle (FIFO empty and no frame in progress)
TX_FULL  output  1  1 = FIFO holds FIFO_DEPTH words
TX_COUNT  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
TX_OVERRUN  output  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset (reset = 0, asynchronous):
  - UART_TX = 1, TX_STATUS = 1, TX_FULL = 0, TX_COUNT = 0, TX_OVERRUN = 0.
  - FIFO is emptied, the FSM goes to IDLE and the baud counter is cleared.
  - This applies mid-frame too: the line returns high immediately and the partial frame is abandoned.
- FIFO writes:
  - A write is accepted on a rising edge when TX_EN = 1 and TX_COUNT < FIFO_DEPTH.
  - If TX_EN = 1 while full, the word is dropped and TX_OVERRUN = 1 for the next cycle.
  - A pop in the same cycle does not free a slot for that cycle's write.
  - Simultaneous accepted write and pop leaves TX_COUNT unchanged.
  - TX_FULL is derived from TX_COUNT == FIFO_DEPTH.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on an edge where FIFO is non-empty, pop the head into the shift register, load the baud counter with CLK_DIV-1, drive UART_TX = 0 and go to START. The start bit therefore begins one cycle after the write edge when the FIFO was empty and IDLE.
  - Every bit, including each stop bit, holds for exactly CLK_DIV cycles. The baud counter decrements each cycle; the transition fires when it reaches 0, reloading CLK_DIV-1.
  - START -> DATA: drive shift[0] (LSB first), bit index = 0.
  - DATA: after bit DATA_BITS-1, go to PAR if PARITY != 0, else STOP.
  - PAR value: even = XOR of the data bits; odd = inverted XOR.
  - STOP: UART_TX = 1 for STOP_BITS*CLK_DIV cycles.
  - At the end of the last stop bit: if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
- Frame length = CLK_DIV*(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) cycles.
- TX_STATUS is registered: 1 only in IDLE with TX_COUNT = 0. It goes to 0 on the cycle after the write edge.
- TX_DATA width is exactly DATA_BITS; no truncation or extension.
- Unknown PARITY values (3) behave as none. STOP_BITS other than 2 behaves as 1.

Test Plan:
- Reset behaviour: assert reset mid-frame (CLK_DIV=4, in DATA) -> UART_TX = 1 within the same cycle; TX_STATUS = 1 and TX_COUNT = 0 after release; no further bits on the line.
- Single frame, 8N1, CLK_DIV=4: write 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Start bit begins 1 cycle after the write. TX_STATUS returns to 1 after 40 cycles.
- Even parity, DATA_BITS=7, CLK_DIV=4: write 0x07 -> parity bit = 1. With PARITY=1 (odd), same data -> parity bit = 0. Frame = 40 cycles.
- Back-to-back, 2 stop bits: write 0x11, 0x22, 0x33 on consecutive cycles -> three contiguous frames with no idle cycles between the final stop bit and the next start bit. TX_COUNT peaks at 2.
- Overflow, FIFO_DEPTH=4: write 6 words (0..5) on consecutive cycles -> words 0..4 transmitted in order; word 5 dropped. TX_OVERRUN pulses once, one cycle after the 6th write. TX_FULL = 1 from the 5th write until the first pop after frame 0 ends.
- Wrap-around: write 10 words in two bursts of 4 and 6, paced by TX_FULL -> all 10 received in order, TX_OVERRUN never asserted.
